reveal_engine: RTL and testbench

REVEAL_ENGINE -- requirements
Module: reveal_engine

---
 rtl/minesweeper_pkg.sv | 7 +
 rtl/cell_fifo.sv | 35 +++
 rtl/reveal_engine.sv | 125 ++++++++++++
 tb/tb_reveal_engine.sv | 299 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/minesweeper_pkg.sv
// minesweeper_pkg: shared FSM state encoding and neighbour offset table for the reveal engine.
package minesweeper_pkg;
    typedef enum logic [2:0] {IDLE, CHECK, POP, REVEAL, NEIGH, DONE} engineState;
    // Row-major neighbour order: dy outer, dx inner, centre cell excluded.
    localparam logic signed [1:0] neighDx [8] = '{-2'sd1, 2'sd0, 2'sd1, -2'sd1, 2'sd1, -2'sd1, 2'sd0, 2'sd1};
    localparam logic signed [1:0] neighDy [8] = '{-2'sd1, -2'sd1, -2'sd1, 2'sd0, 2'sd0, 2'sd1, 2'sd1, 2'sd1};
endpackage

// File: rtl/cell_fifo.sv
// cell_fifo: synchronous FIFO of packed cell coordinates with a combinational head output.
module cell_fifo #(
    parameter int depth = 64,
    parameter int width = 6
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic             pop,
    input  logic [width-1:0] pushData,
    output logic [width-1:0] headData,
    output logic             empty
);
    localparam int AW = depth > 1 ? $clog2(depth) : 1;
    localparam logic [AW-1:0] LAST = AW'(depth - 1);
    logic [width-1:0] mem [depth];
    logic [AW-1:0] head, tail;
    logic [AW:0] count;
    assign headData = mem[head];
    assign empty = count == '0;
    always_ff @(posedge clk) begin
        if (reset) begin
            head <= '0;
            tail <= '0;
            count <= '0;
        end else begin
            if (push) begin
                mem[tail] <= pushData;
                tail <= tail == LAST ? '0 : tail + 1'b1;
            end
            if (pop) head <= head == LAST ? '0 : head + 1'b1;
            count <= count + (AW+1)'(push) - (AW+1)'(pop);
        end
    end
endmodule

// File: rtl/reveal_engine.sv
// reveal_engine: breadth-first flood reveal of a minesweeper board from a clicked cell.
// Define REVEAL_COUNT_EN to add the revealCount output.
module reveal_engine
    import minesweeper_pkg::*;
#(
    parameter int width = 8,
    parameter int height = 8
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      start,
    input  logic [$clog2(width)-1:0]  clickX,
    input  logic [$clog2(height)-1:0] clickY,
    output logic [$clog2(width)-1:0]  readX,
    output logic [$clog2(height)-1:0] readY,
    input  logic                      mineValue,
    input  logic [3:0]                adjValue,
    output logic                      revealEn,
    output logic [$clog2(width)-1:0]  revealX,
    output logic [$clog2(height)-1:0] revealY,
    output logic                      busy,
    output logic                      done,
    output logic                      hitMine
`ifdef REVEAL_COUNT_EN
    ,
    output logic [$clog2(width*height+1)-1:0] revealCount
`endif
);
    localparam int XW = $clog2(width);
    localparam int YW = $clog2(height);
    localparam int CELLS = width * height;
    localparam int IW = $clog2(CELLS);

    engineState state, nextState;
    logic [XW-1:0] tgtX, curX;
    logic [YW-1:0] tgtY, curY;
    logic [2:0] neighIdx;
    logic [CELLS-1:0] visited;
    logic [XW+1:0] nx;
    logic [YW+1:0] ny;
    logic nbOk, mark, push, pop, fifoEmpty;
    logic [IW-1:0] clickIdx, nbIdx, markIdx;
    logic [XW+YW-1:0] pushCell, headCell;

    cell_fifo #(.depth(CELLS), .width(XW + YW)) fifo (
        .clk(clk),
        .reset(reset),
        .push(push),
        .pop(pop),
        .pushData(pushCell),
        .headData(headCell),
        .empty(fifoEmpty)
    );

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else state <= nextState;
    end

    always_comb begin
        nextState = state;
        case (state)
            IDLE:    nextState = start ? CHECK : IDLE;
            CHECK:   nextState = (visited[clickIdx] || mineValue) ? DONE : POP;
            POP:     nextState = fifoEmpty ? DONE : REVEAL;
            REVEAL:  nextState = adjValue == 4'd0 ? NEIGH : POP;
            NEIGH:   nextState = neighIdx == 3'd7 ? POP : NEIGH;
            default: nextState = IDLE;
        endcase
    end

    // Neighbour coordinates carry two extra bits so -1 and width are detectable as out of bounds.
    always_comb begin
        nx = {2'b00, curX} + {{XW{neighDx[neighIdx][1]}}, neighDx[neighIdx]};
        ny = {2'b00, curY} + {{YW{neighDy[neighIdx][1]}}, neighDy[neighIdx]};
        nbOk = !nx[XW+1] && nx[XW:0] < (XW+1)'(width) && !ny[YW+1] && ny[YW:0] < (YW+1)'(height);
        nbIdx = IW'(ny[YW-1:0]) * IW'(width) + IW'(nx[XW-1:0]);
        clickIdx = IW'(tgtY) * IW'(width) + IW'(tgtX);
    end

    always_comb begin
        mark = state == CHECK ? !visited[clickIdx] : state == NEIGH && nbOk && !visited[nbIdx];
        markIdx = state == CHECK ? clickIdx : nbIdx;
        push = mark && !(state == CHECK && mineValue);
        pushCell = state == CHECK ? {tgtY, tgtX} : {ny[YW-1:0], nx[XW-1:0]};
        pop = state == POP && !fifoEmpty;
        busy = state inside {CHECK, POP, REVEAL, NEIGH};
        done = state == DONE;
        revealEn = state == REVEAL || (state == CHECK && mark && mineValue);
        readX = state == CHECK ? tgtX : (state == REVEAL || state == NEIGH) ? curX : '0;
        readY = state == CHECK ? tgtY : (state == REVEAL || state == NEIGH) ? curY : '0;
        revealX = revealEn ? readX : '0;
        revealY = revealEn ? readY : '0;
    end

    // A mine click is also marked visited so no cell is ever revealed twice between resets.
    always_ff @(posedge clk) begin
        if (reset) begin
            visited <= '0;
            hitMine <= 1'b0;
            tgtX <= '0;
            tgtY <= '0;
            curX <= '0;
            curY <= '0;
            neighIdx <= '0;
        end else begin
            if (state == IDLE && start) begin
                tgtX <= clickX;
                tgtY <= clickY;
                hitMine <= 1'b0;
            end
            if (mark) visited[markIdx] <= 1'b1;
            if (state == CHECK && mark && mineValue) hitMine <= 1'b1;
            if (pop) {curY, curX} <= headCell;
            neighIdx <= state == NEIGH ? neighIdx + 3'd1 : 3'd0;
        end
    end

`ifdef REVEAL_COUNT_EN
    always_ff @(posedge clk) begin
        if (reset) revealCount <= '0;
        else if (revealEn) revealCount <= revealCount + 1'b1;
    end
`endif
endmodule

// File: tb/tb_reveal_engine.sv
// tb_reveal_engine: randomized and directed flood-reveal scenarios against a BFS board model.
module tb_reveal_engine;
    localparam int W = 8;
    localparam int H = 8;
    localparam int N = W * H;

    logic clk_tb = 1'b0;
    logic reset_tb = 1'b1;
    logic start = 1'b0;
    logic [2:0] clickX = '0, clickY = '0;
    logic [2:0] readX, readY, revealX, revealY;
    logic mineValue, revealEn, busy, done, hitMine;
    logic [3:0] adjValue;
`ifdef REVEAL_COUNT_EN
    logic [6:0] revealCount;
`endif

    bit mines [N];
    logic [3:0] adjTab [N];
    bit modelVisited [N];
    bit dutRevealed [N];
    int modelTotal = 0;
    int expSeq [$];
    bit expHit;
    int errors = 0;
    int checks = 0;

    always #5 clk_tb = ~clk_tb;

    assign mineValue = mines[{readY, readX}];
    assign adjValue = adjTab[{readY, readX}];

    reveal_engine #(.width(W), .height(H)) dut (
        .clk(clk_tb),
        .reset(reset_tb),
        .start(start),
        .clickX(clickX),
        .clickY(clickY),
        .readX(readX),
        .readY(readY),
        .mineValue(mineValue),
        .adjValue(adjValue),
        .revealEn(revealEn),
        .revealX(revealX),
        .revealY(revealY),
        .busy(busy),
        .done(done),
        .hitMine(hitMine)
`ifdef REVEAL_COUNT_EN
        ,
        .revealCount(revealCount)
`endif
    );

    function automatic bit onBoard(input int x, input int y);
        return x >= 0 && x < W && y >= 0 && y < H;
    endfunction

    task automatic clearBoard();
        for (int i = 0; i < N; i++) mines[i] = 1'b0;
    endtask

    task automatic addMine(input int x, input int y);
        mines[y * W + x] = 1'b1;
    endtask

    task automatic computeAdj();
        for (int y = 0; y < H; y++)
            for (int x = 0; x < W; x++) begin
                int n = 0;
                for (int dy = -1; dy <= 1; dy++)
                    for (int dx = -1; dx <= 1; dx++)
                        if ((dx != 0 || dy != 0) && onBoard(x + dx, y + dy) && mines[(y + dy) * W + x + dx]) n++;
                adjTab[y * W + x] = 4'(n);
            end
    endtask

    // Breadth-first expansion from the click: zero-count cells open their unvisited neighbours.
    task automatic modelClick(input int x, input int y);
        int q [$];
        int c;
        expSeq.delete();
        expHit = 1'b0;
        c = y * W + x;
        if (modelVisited[c]) return;
        modelVisited[c] = 1'b1;
        if (mines[c]) begin
            expSeq.push_back(c);
            expHit = 1'b1;
            return;
        end
        q.push_back(c);
        while (q.size() > 0) begin
            c = q.pop_front();
            expSeq.push_back(c);
            if (adjTab[c] == 4'd0)
                for (int dy = -1; dy <= 1; dy++)
                    for (int dx = -1; dx <= 1; dx++) begin
                        int px = c % W + dx;
                        int py = c / W + dy;
                        if ((dx != 0 || dy != 0) && onBoard(px, py) && !modelVisited[py * W + px]) begin
                            modelVisited[py * W + px] = 1'b1;
                            q.push_back(py * W + px);
                        end
                    end
        end
    endtask

    task automatic resetDut();
        @(negedge clk_tb);
        reset_tb = 1'b1;
        start = 1'b0;
        @(negedge clk_tb);
        reset_tb = 1'b0;
        for (int i = 0; i < N; i++) begin
            modelVisited[i] = 1'b0;
            dutRevealed[i] = 1'b0;
        end
        modelTotal = 0;
    endtask

    // Clicks a cell, collects every reveal until done, and compares against the model.
    task automatic runClick(input int x, input int y, input int pulseAt, input string name);
        int got [$];
        bit seenDone = 1'b0;
        bit seenHit = 1'b0;
        int extra = 0;
        modelClick(x, y);
        start = 1'b1;
        clickX = 3'(x);
        clickY = 3'(y);
        for (int cyc = 0; cyc < 2000 && !seenDone; cyc++) begin
            @(negedge clk_tb);
            start = cyc == pulseAt;
            if (cyc == pulseAt) begin
                clickX = 3'($urandom_range(7));
                clickY = 3'($urandom_range(7));
                checks++;
                if (busy !== 1'b1) begin
                    errors++;
                    $display("FAIL %s busy_at_pulse: got %b expected 1", name, busy);
                end
            end
            if (revealEn === 1'b1) begin
                got.push_back(int'({revealY, revealX}));
                dutRevealed[{revealY, revealX}] = 1'b1;
            end
            if (done === 1'b1) begin
                seenDone = 1'b1;
                seenHit = hitMine;
            end
        end
        start = 1'b0;
        checks++;
        if (!seenDone) begin
            errors++;
            $display("FAIL %s done_timeout: got no done expected done within 2000 cycles", name);
        end
        checks++;
        if (seenHit !== expHit) begin
            errors++;
            $display("FAIL %s hitMine: got %b expected %b", name, seenHit, expHit);
        end
        checks++;
        if (got.size() != expSeq.size()) begin
            errors++;
            $display("FAIL %s reveal_count: got %0d expected %0d", name, got.size(), expSeq.size());
        end
        for (int i = 0; i < got.size() && i < expSeq.size(); i++) begin
            checks++;
            if (got[i] != expSeq[i]) begin
                errors++;
                $display("FAIL %s reveal_order[%0d]: got cell %0d expected cell %0d", name, i, got[i], expSeq[i]);
            end
        end
        modelTotal += expSeq.size();
        repeat (3) begin
            @(negedge clk_tb);
            if (revealEn !== 1'b0 || busy !== 1'b0 || done !== 1'b0) extra++;
        end
        checks++;
        if (extra != 0 || hitMine !== expHit) begin
            errors++;
            $display("FAIL %s idle_after: got %0d active cycles hitMine=%b expected 0 active hitMine=%b", name, extra, hitMine, expHit);
        end
`ifdef REVEAL_COUNT_EN
        checks++;
        if (revealCount !== 7'(modelTotal)) begin
            errors++;
            $display("FAIL %s revealCount: got %0d expected %0d", name, revealCount, modelTotal);
        end
`endif
    endtask

    task automatic test_reset();
        reset_tb = 1'b1;
        repeat (2) @(negedge clk_tb);
        checks++;
        if ({busy, done, hitMine, revealEn} !== 4'b0000) begin
            errors++;
            $display("FAIL reset_flags: got busy=%b done=%b hitMine=%b revealEn=%b expected all 0", busy, done, hitMine, revealEn);
        end
        checks++;
        if ({readX, readY, revealX, revealY} !== 12'd0) begin
            errors++;
            $display("FAIL reset_addr: got read=%0d,%0d reveal=%0d,%0d expected 0", readX, readY, revealX, revealY);
        end
        reset_tb = 1'b0;
    endtask

    task automatic test_mine_click();
        resetDut();
        clearBoard();
        addMine(3, 3);
        computeAdj();
        runClick(3, 3, -1, "mine_click");
    endtask

    task automatic test_adjacent_click();
        resetDut();
        clearBoard();
        addMine(1, 1);
        computeAdj();
        runClick(2, 2, -1, "adjacent_click");
    endtask

    task automatic test_full_flood();
        resetDut();
        clearBoard();
        computeAdj();
        runClick(0, 0, 10, "full_flood");
        checks++;
        if (modelTotal != N) begin
            errors++;
            $display("FAIL full_flood_total: got %0d expected %0d", modelTotal, N);
        end
    endtask

    task automatic test_partial_flood();
        resetDut();
        clearBoard();
        addMine(1, 1);
        computeAdj();
        runClick(7, 7, -1, "partial_flood");
        checks++;
        if (dutRevealed[9] !== 1'b0 || dutRevealed[0] !== 1'b0) begin
            errors++;
            $display("FAIL partial_flood_excluded: got (1,1)=%b (0,0)=%b expected 0 0", dutRevealed[9], dutRevealed[0]);
        end
        runClick(5, 5, 0, "revisit_with_busy_start");
    endtask

    task automatic test_reset_mid_flood();
        resetDut();
        clearBoard();
        computeAdj();
        start = 1'b1;
        clickX = 3'd0;
        clickY = 3'd0;
        @(negedge clk_tb);
        start = 1'b0;
        repeat (19) @(negedge clk_tb);
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("FAIL mid_flood_busy: got %b expected 1", busy);
        end
        reset_tb = 1'b1;
        @(negedge clk_tb);
        checks++;
        if ({busy, revealEn, done, hitMine} !== 4'b0000) begin
            errors++;
            $display("FAIL mid_flood_reset: got busy=%b revealEn=%b done=%b hitMine=%b expected all 0", busy, revealEn, done, hitMine);
        end
        resetDut();
        runClick(0, 0, -1, "reflood_after_reset");
    endtask

    task automatic test_random_boards();
        for (int b = 0; b < 4; b++) begin
            resetDut();
            for (int i = 0; i < N; i++) mines[i] = $urandom_range(99) < 12;
            computeAdj();
            for (int k = 0; k < 5; k++) runClick(int'($urandom_range(7)), int'($urandom_range(7)), -1, "random_click");
        end
    endtask

    initial begin
        test_reset();
        test_mine_click();
        test_adjacent_click();
        test_full_flood();
        test_partial_flood();
        test_reset_mid_flood();
        test_random_boards();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
